lifo_stack_param: RTL and testbench

//   Parametrised LIFO stack, successor to the fixed 4-bit RW-controlled stack.

---
 rtl/lifo_stack_param.sv | 111 +++++++++++
 tb/tb_lifo_stack_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with same-cycle push/pop exchange,
// occupancy count, almost-full threshold and sticky error flags.
module lifo_stack_param #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       EN,
    input  logic                       PUSH,
    input  logic                       POP,
    input  logic                       CLR_ERR,
    input  logic [WIDTH-1:0]           dataIn,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       VALID,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       ALMOST_FULL,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    ptr_nxt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;
    logic             out_ld;
    logic [WIDTH-1:0] out_nxt;
    logic             ov_set;
    logic             un_set;
    logic             empty;
    logic             full;

    assign empty   = (ptr == '0);
    assign full    = (ptr == CW'(DEPTH));
    assign top_idx = AW'(ptr - CW'(1));

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = AW'(ptr);
        ptr_nxt = ptr;
        out_ld  = 1'b0;
        out_nxt = mem[top_idx];
        ov_set  = 1'b0;
        un_set  = 1'b0;
        if (EN) begin
            if (PUSH && POP) begin
                // exchange replaces the top in place; on empty it bypasses
                out_ld = 1'b1;
                if (empty) begin
                    out_nxt = dataIn;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end else if (PUSH) begin
                if (full) begin
                    ov_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + CW'(1);
                end
            end else if (POP) begin
                if (empty) begin
                    un_set = 1'b1;
                end else begin
                    out_ld  = 1'b1;
                    ptr_nxt = ptr - CW'(1);
                end
            end
        end
    end

    // storage is deliberately not cleared by reset
    always_ff @(posedge Clk) begin
        if (Rst_n && wr_en) begin
            mem[wr_idx] <= dataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ptr       <= '0;
            dataOut   <= '0;
            VALID     <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            VALID <= out_ld;
            if (out_ld) begin
                dataOut <= out_nxt;
            end
            OVERFLOW  <= (OVERFLOW & ~(EN & CLR_ERR)) | ov_set;
            UNDERFLOW <= (UNDERFLOW & ~(EN & CLR_ERR)) | un_set;
        end
    end

    assign COUNT       = ptr;
    assign EMPTY       = empty;
    assign FULL        = full;
    assign ALMOST_FULL = (ptr >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_lifo_stack_param.sv
// Bench for lifo_stack_param: two instances (8 deep and 5 deep)
// share stimulus and are compared against a queue-based model.
module tb_lifo_stack_param;

    logic       Clk;
    logic       rst_n;
    logic       en;
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] din;

    logic [3:0] o8;
    logic       v8;
    logic [3:0] c8;
    logic       e8, f8, a8, ov8, un8;
    logic [3:0] o5;
    logic       v5;
    logic [2:0] c5;
    logic       e5, f5, a5, ov5, un5;

    int total = 0;
    int bad   = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    int         depth[2] = '{8, 5};
    int         thr[2]   = '{7, 3};
    logic [3:0] mout[2];
    logic       mval[2];
    logic       mov[2];
    logic       mun[2];
    int         msz[2];

    lifo_stack_param u8 (
        .Clk(Clk), .Rst_n(rst_n), .EN(en), .PUSH(push), .POP(pop),
        .CLR_ERR(clr), .dataIn(din), .dataOut(o8), .VALID(v8),
        .COUNT(c8), .EMPTY(e8), .FULL(f8), .ALMOST_FULL(a8),
        .OVERFLOW(ov8), .UNDERFLOW(un8)
    );

    lifo_stack_param #(.WIDTH(4), .DEPTH(5), .AFULL_THRESH(3)) u5 (
        .Clk(Clk), .Rst_n(rst_n), .EN(en), .PUSH(push), .POP(pop),
        .CLR_ERR(clr), .dataIn(din), .dataOut(o5), .VALID(v5),
        .COUNT(c5), .EMPTY(e5), .FULL(f5), .ALMOST_FULL(a5),
        .OVERFLOW(ov5), .UNDERFLOW(un5)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int k, input logic [3:0] o, input logic v,
                           input logic [3:0] c, input logic e,
                           input logic f, input logic a,
                           input logic ov, input logic un);
        string p;
        p = (k == 0) ? "d8" : "d5";
        chk({p, ".dataOut"}, 32'(o), 32'(mout[k]));
        chk({p, ".VALID"}, 32'(v), 32'(mval[k]));
        chk({p, ".COUNT"}, 32'(c), 32'(msz[k]));
        chk({p, ".EMPTY"}, 32'(e), 32'(msz[k] == 0));
        chk({p, ".FULL"}, 32'(f), 32'(msz[k] == depth[k]));
        chk({p, ".ALMOST_FULL"}, 32'(a), 32'(msz[k] >= thr[k]));
        chk({p, ".OVERFLOW"}, 32'(ov), 32'(mov[k]));
        chk({p, ".UNDERFLOW"}, 32'(un), 32'(mun[k]));
    endtask

    task automatic model_step();
        logic [3:0] q[$];
        logic       ovs, uns;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) q = qa;
            else q = qb;
            if (!rst_n) begin
                q.delete();
                mout[k] = 4'h0;
                mval[k] = 1'b0;
                mov[k]  = 1'b0;
                mun[k]  = 1'b0;
            end else begin
                ovs     = 1'b0;
                uns     = 1'b0;
                mval[k] = 1'b0;
                if (en) begin
                    if (push && pop) begin
                        if (q.size() == 0) begin
                            mout[k] = din;
                        end else begin
                            mout[k] = q[q.size()-1];
                            q[q.size()-1] = din;
                        end
                        mval[k] = 1'b1;
                    end else if (push) begin
                        if (q.size() == depth[k]) ovs = 1'b1;
                        else q.push_back(din);
                    end else if (pop) begin
                        if (q.size() == 0) begin
                            uns = 1'b1;
                        end else begin
                            mout[k] = q.pop_back();
                            mval[k] = 1'b1;
                        end
                    end
                    if (clr) begin
                        mov[k] = 1'b0;
                        mun[k] = 1'b0;
                    end
                    if (ovs) mov[k] = 1'b1;
                    if (uns) mun[k] = 1'b1;
                end
            end
            msz[k] = q.size();
            if (k == 0) qa = q;
            else qb = q;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clk);
        #1;
        chk_dut(0, o8, v8, c8, e8, f8, a8, ov8, un8);
        chk_dut(1, o5, v5, {1'b0, c5}, e5, f5, a5, ov5, un5);
    endtask

    task automatic drive(input logic r, input logic e, input logic pu,
                         input logic po, input logic cl,
                         input logic [3:0] d);
        rst_n = r;
        en    = e;
        push  = pu;
        pop   = po;
        clr   = cl;
        din   = d;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        clr   = 1'b0;
        din   = 4'h0;
        #2;
        drive(0, 0, 0, 0, 0, 4'h0);
        drive(0, 1, 1, 1, 1, 4'h3);

        for (int i = 1; i <= 8; i++) drive(1, 1, 1, 0, 0, 4'(i));
        drive(1, 1, 1, 0, 0, 4'hF);
        drive(1, 1, 1, 1, 0, 4'hA);
        drive(1, 1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 1, 0, 4'h0);

        drive(1, 1, 0, 1, 0, 4'h0);
        drive(1, 1, 0, 1, 1, 4'h0);
        drive(1, 1, 0, 0, 1, 4'h0);
        drive(1, 1, 1, 1, 0, 4'h5);

        for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 0, 4'(i + 9));
        for (int i = 0; i < 4; i++)
            drive(1, 0, 1'(i), 1'(~i), 1'(i >> 1), 4'hE);
        drive(0, 1, 1, 0, 0, 4'h7);
        drive(1, 1, 0, 0, 0, 4'h0);

        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            drive($urandom_range(99) >= 2,
                  $urandom_range(99) < 85,
                  $urandom_range(99) < bias,
                  $urandom_range(99) < (100 - bias),
                  $urandom_range(99) < 10,
                  4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
